// File: rtl/dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dm_access_ctrl
// Description : Load/store controller for the 64x32 data memory. It performs
//               read-modify-write for sub-word stores and lane extraction
//               with sign or zero extension for loads.
// Revision    : 1.0 - initial release
// ============================================================================
module dm_access_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk_dm,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-3:0] DM_Addr,
    output logic              Mem_Write,
    output logic [DATA_W-1:0] M_W_Data,
    input  logic [DATA_W-1:0] M_R_Data
);

    localparam logic [1:0] c_SIZE_B = 2'b00;
    localparam logic [1:0] c_SIZE_H = 2'b01;
    localparam logic [1:0] c_SIZE_W = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_we;
    logic [1:0]         r_size;
    logic               r_unsigned;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_rdata;
    logic               r_err;

    logic               w_illegal;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [DATA_W-1:0]  w_load;
    logic [DATA_W-1:0]  w_merge;

    always_comb begin
        w_illegal = 1'b0;
        case (req_size)
            c_SIZE_B: w_illegal = 1'b0;
            c_SIZE_H: w_illegal = req_addr[0];
            c_SIZE_W: w_illegal = (req_addr[1:0] != 2'b00);
            default:  w_illegal = 1'b1;
        endcase
    end

    always_comb begin
        w_byte = M_R_Data[7:0];
        case (r_addr[1:0])
            2'd0:    w_byte = M_R_Data[7:0];
            2'd1:    w_byte = M_R_Data[15:8];
            2'd2:    w_byte = M_R_Data[23:16];
            default: w_byte = M_R_Data[31:24];
        endcase
        w_half = r_addr[1] ? M_R_Data[31:16] : M_R_Data[15:0];
    end

    always_comb begin
        w_load = M_R_Data;
        case (r_size)
            c_SIZE_B: w_load = r_unsigned ? {{(DATA_W-8){1'b0}}, w_byte}
                                          : {{(DATA_W-8){w_byte[7]}}, w_byte};
            c_SIZE_H: w_load = r_unsigned ? {{(DATA_W-16){1'b0}}, w_half}
                                          : {{(DATA_W-16){w_half[15]}}, w_half};
            default:  w_load = M_R_Data;
        endcase
    end

    // Sub-word stores overwrite only the addressed lane of the current word.
    always_comb begin
        w_merge = M_R_Data;
        case (r_size)
            c_SIZE_B: begin
                case (r_addr[1:0])
                    2'd0:    w_merge[7:0]   = r_wdata[7:0];
                    2'd1:    w_merge[15:8]  = r_wdata[7:0];
                    2'd2:    w_merge[23:16] = r_wdata[7:0];
                    default: w_merge[31:24] = r_wdata[7:0];
                endcase
            end
            c_SIZE_H: begin
                if (r_addr[1]) w_merge[31:16] = r_wdata[15:0];
                else           w_merge[15:0]  = r_wdata[15:0];
            end
            default: w_merge = r_wdata;
        endcase
    end

    always_ff @(posedge clk_dm or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_we       <= 1'b0;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we       <= req_we;
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_illegal) begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    r_err   <= 1'b0;
                    r_rdata <= r_we ? '0 : w_load;
                    r_state <= S_RESP;
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The memory writes every edge, so outside a store we echo its read data.
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = (r_state == S_RESP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign DM_Addr   = r_addr[ADDR_W-1:2];
    assign Mem_Write = (r_state == S_ACCESS) && r_we;
    assign M_W_Data  = Mem_Write ? w_merge : M_R_Data;

endmodule
`default_nettype wire

// File: tb/tb_dm_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dm_access_ctrl
// Description : Directed vector bench for dm_access_ctrl with a 64x32 memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_access_ctrl;

    logic        clk_dm = 1'b0;
    logic        rst    = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [7:0]  req_addr = 8'h00;
    logic [31:0] req_wdata = 32'h0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [5:0]  DM_Addr;
    logic        Mem_Write;
    logic [31:0] M_W_Data;
    logic [31:0] M_R_Data;

    logic [31:0] mem [64];

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk_dm = ~clk_dm;

    // Data memory: unconditional write of M_W_Data on every rising edge.
    assign M_R_Data = mem[DM_Addr];
    always @(posedge clk_dm) mem[DM_Addr] <= M_W_Data;

    dm_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk_dm       (clk_dm),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .DM_Addr      (DM_Addr),
        .Mem_Write    (Mem_Write),
        .M_W_Data     (M_W_Data),
        .M_R_Data     (M_R_Data)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [7:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          idle;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int n;
        repeat (v.idle) begin
            @(posedge clk_dm); #1;
        end
        chk({tag, " ready_before"}, 32'(req_ready), 32'd1);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        @(posedge clk_dm); #1;
        req_valid = 1'b0;
        n = 1;
        while (!rsp_valid && n < 8) begin
            chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
            @(posedge clk_dm); #1;
            n++;
        end
        chk({tag, " latency"}, 32'(n), v.exp_err ? 32'd1 : 32'd2);
        chk({tag, " ready_resp"}, 32'(req_ready), 32'd0);
        chk({tag, " rdata"}, rsp_rdata, v.exp_rdata);
        chk({tag, " err"}, 32'(rsp_err), 32'(v.exp_err));
        @(posedge clk_dm); #1;
        chk({tag, " rsp_single"}, 32'(rsp_valid), 32'd0);
        chk({tag, " ready_after"}, 32'(req_ready), 32'd1);
        chk({tag, " rdata_hold"}, rsp_rdata, v.exp_rdata);
    endtask

    initial begin
        // we size uns addr wdata exp_rdata err idle
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 1'b0, 0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h11, 32'h000000AA, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'hDEADAAEF, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h11, 32'h0,        32'hFFFFFFAA, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b1, 8'h11, 32'h0,        32'h000000AA, 1'b0, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h12, 32'h00001234, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h1234AAEF, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h12, 32'h0,        32'h00001234, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b0, 8'h10, 32'h0,        32'hFFFFAAEF, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h13, 32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{1'b1, 2'b01, 1'b0, 8'h11, 32'h0000FFFF, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b1, 2'b11, 1'b0, 8'h10, 32'h00000000, 32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 2'b11, 1'b1, 8'h10, 32'h0,        32'h0,        1'b1, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h10, 32'h0,        32'h1234AAEF, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h10, 32'h0,        32'h0000AAEF, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h13, 32'h0,        32'h00000012, 1'b0, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'h7C, 32'h11111111, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b1, 2'b10, 1'b0, 8'hFC, 32'h22222222, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'h7C, 32'h0,        32'h11111111, 1'b0, 20});
        vecs.push_back('{1'b0, 2'b10, 1'b0, 8'hFC, 32'h0,        32'h22222222, 1'b0, 0});
        vecs.push_back('{1'b1, 2'b00, 1'b0, 8'h13, 32'hFFFFFF80, 32'h0,        1'b0, 0});
        vecs.push_back('{1'b0, 2'b00, 1'b0, 8'h13, 32'h0,        32'hFFFFFF80, 1'b0, 0});
        vecs.push_back('{1'b0, 2'b01, 1'b1, 8'h12, 32'h0,        32'h00008034, 1'b0, 0});

        #12;
        chk("reset ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rdata", rsp_rdata, 32'h0);
        chk("reset err", 32'(rsp_err), 32'd0);
        chk("reset dm_addr", 32'(DM_Addr), 32'd0);
        chk("reset mem_write", 32'(Mem_Write), 32'd0);
        chk("reset refresh", M_W_Data, M_R_Data);
        @(posedge clk_dm); #1;
        rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("v%0d", i));
        chk("idle mem_write", 32'(Mem_Write), 32'd0);
        chk("idle refresh", M_W_Data, M_R_Data);

        // Reset during the ACCESS cycle of a byte store must not land it.
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr  = 8'h10; req_wdata = 32'h00000055;
        @(posedge clk_dm); #1;
        req_valid = 1'b0;
        chk("rstmid in_access", 32'(Mem_Write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstmid mem_write_drop", 32'(Mem_Write), 32'd0);
        chk("rstmid refresh", M_W_Data, M_R_Data);
        chk("rstmid ready", 32'(req_ready), 32'd1);
        chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk_dm); #1;
        rst = 1'b0;
        chk("rstmid ready_after", 32'(req_ready), 32'd1);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rstmid no_rsp%0d", k), 32'(rsp_valid), 32'd0);
            @(posedge clk_dm); #1;
        end
        run_vec('{1'b0, 2'b10, 1'b0, 8'h10, 32'h0, 32'h8034AAEF, 1'b0, 0}, "rstmid readback_w");
        run_vec('{1'b0, 2'b00, 1'b1, 8'h10, 32'h0, 32'h000000EF, 1'b0, 0}, "rstmid readback_b");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
